// File: rtl/mc_control.sv
// mc_control: multicycle control FSM sequencing the shared MIPS-lite datapath.
// Define MC_PERF_CNT_EN to add the retired/stall_cycles performance counters.
module mc_control #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  input  logic            neg,
  input  logic            mem_ready,
  output logic            pcwrite,
  output logic            pcwritecond,
  output logic            iord,
  output logic            memread,
  output logic            memwrite,
  output logic            irwrite,
  output logic            memtoreg,
  output logic            regwrite,
  output logic            alusrca,
  output logic [1:0]      regdest,
  output logic [1:0]      alusrcb,
  output logic [2:0]      aluop,
  output logic [1:0]      pcsource,
  output logic [ST_W-1:0] state,
  output logic            instr_done,
  output logic            illegal
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]     retired,
  output logic [31:0]     stall_cycles
`endif
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = ST_W'(0),
    S_DECODE = ST_W'(1),
    S_MEMADR = ST_W'(2),
    S_MEMRD  = ST_W'(3),
    S_MEMWB  = ST_W'(4),
    S_MEMWR  = ST_W'(5),
    S_REXEC  = ST_W'(6),
    S_RWB    = ST_W'(7),
    S_BEQ    = ST_W'(8),
    S_IEXEC  = ST_W'(9),
    S_IWB    = ST_W'(10),
    S_LINK   = ST_W'(11),
    S_JREG   = ST_W'(12)
  } state_t;

  localparam logic [OP_W-1:0] OP_R      = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_LW     = OP_W'('h23);
  localparam logic [OP_W-1:0] OP_SW     = OP_W'('h2B);
  localparam logic [OP_W-1:0] OP_BEQ    = OP_W'('h04);
  localparam logic [OP_W-1:0] OP_NORI   = OP_W'('h0F);
  localparam logic [OP_W-1:0] OP_BLEZAL = OP_W'('h24);
  localparam logic [OP_W-1:0] OP_JALPC  = OP_W'('h1F);
  localparam logic [OP_W-1:0] OP_BALN   = OP_W'('h1B);

  localparam logic [OP_W-1:0] FN_JMXOR = OP_W'('h21);
  localparam logic [OP_W-1:0] FN_BRV   = OP_W'('h14);
  localparam logic [OP_W-1:0] FN_ADD   = OP_W'('h20);
  localparam logic [OP_W-1:0] FN_SUB   = OP_W'('h22);
  localparam logic [OP_W-1:0] FN_AND   = OP_W'('h24);
  localparam logic [OP_W-1:0] FN_OR    = OP_W'('h25);
  localparam logic [OP_W-1:0] FN_NOR   = OP_W'('h27);
  localparam logic [OP_W-1:0] FN_SLT   = OP_W'('h2A);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  logic is_r, is_lw, is_sw, is_beq, is_nori;
  logic is_blezal, is_jalpc, is_baln, is_link;
  logic is_jmxor, is_brv, is_ralu, alu_fn_ok;

  always_comb begin
    is_r      = (opcode == OP_R);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_beq    = (opcode == OP_BEQ);
    is_nori   = (opcode == OP_NORI);
    is_blezal = (opcode == OP_BLEZAL);
    is_jalpc  = (opcode == OP_JALPC);
    is_baln   = (opcode == OP_BALN);
    is_link   = is_blezal | is_jalpc | is_baln;
    alu_fn_ok = (funct == FN_ADD) | (funct == FN_SUB)
              | (funct == FN_AND) | (funct == FN_OR)
              | (funct == FN_NOR) | (funct == FN_SLT);
    is_jmxor  = is_r & (funct == FN_JMXOR);
    is_brv    = is_r & (funct == FN_BRV);
    is_ralu   = is_r & alu_fn_ok;
  end

  logic pcwrite_r, pcwritecond_r, memwrite_r;
  logic irwrite_r, regwrite_r, done_r;

  always_comb begin
    state_d       = S_FETCH;
    illegal_d     = illegal_q;
    pcwrite_r     = 1'b0;
    pcwritecond_r = 1'b0;
    iord          = 1'b0;
    memread       = 1'b0;
    memwrite_r    = 1'b0;
    irwrite_r     = 1'b0;
    memtoreg      = 1'b0;
    regwrite_r    = 1'b0;
    alusrca       = 1'b0;
    regdest       = 2'd0;
    alusrcb       = 2'd0;
    aluop         = 3'd0;
    pcsource      = 2'd0;
    done_r        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'd1;
        if (mem_ready) begin
          irwrite_r = 1'b1;
          pcwrite_r = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'd3;
        unique case (1'b1)
          is_lw, is_sw:     state_d = S_MEMADR;
          is_brv:           state_d = S_JREG;
          is_jmxor,
          is_ralu:          state_d = S_REXEC;
          is_beq:           state_d = S_BEQ;
          is_nori:          state_d = S_IEXEC;
          is_link:          state_d = S_LINK;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        state_d = is_lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite_r = 1'b1;
        memtoreg   = 1'b1;
        done_r     = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_r = 1'b1;
        if (mem_ready) begin
          done_r  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = 3'd2;
        state_d = S_RWB;
      end
      S_RWB: begin
        regwrite_r = 1'b1;
        regdest    = 2'd1;
        done_r     = 1'b1;
        // jmxor links $31 and jumps to the xor target left in ALUOut
        if (is_jmxor) begin
          regdest   = 2'd2;
          pcwrite_r = 1'b1;
          pcsource  = 2'd1;
        end
      end
      S_BEQ: begin
        alusrca       = 1'b1;
        aluop         = 3'd1;
        pcwritecond_r = 1'b1;
        pcsource      = 2'd1;
        done_r        = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'd2;
        aluop   = 3'd3;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite_r = 1'b1;
        done_r     = 1'b1;
      end
      S_LINK: begin
        regwrite_r = 1'b1;
        regdest    = 2'd2;
        done_r     = 1'b1;
        if (is_jalpc) begin
          pcwrite_r = 1'b1;
          pcsource  = 2'd1;
        end else if (is_baln) begin
          pcwrite_r = neg;
          pcsource  = 2'd2;
        end else begin
          alusrca   = 1'b1;
          aluop     = 3'd1;
          pcwrite_r = zero | neg;
          pcsource  = 2'd1;
        end
      end
      S_JREG: begin
        pcwrite_r = 1'b1;
        pcsource  = 2'd3;
        done_r    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Writes are suppressed while reset is held so an aborted access is clean
  always_comb begin
    pcwrite     = pcwrite_r & rst_n;
    pcwritecond = pcwritecond_r & rst_n;
    memwrite    = memwrite_r & rst_n;
    irwrite     = irwrite_r & rst_n;
    regwrite    = regwrite_r & rst_n;
    instr_done  = done_r & rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;
  logic        mem_wait;

  always_comb begin
    mem_wait  = !mem_ready && ((state_q == S_FETCH)
              || (state_q == S_MEMRD) || (state_q == S_MEMWR));
    retired_d = retired_q;
    stall_d   = stall_q;
    if (done_r)
      retired_d = retired_q + 32'd1;
    if (mem_wait)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
      stall_q   <= 32'd0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired      = retired_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed and random instruction streams against a plan model.
// Each instruction is expanded into its expected per-cycle state/strobe steps.
module tb_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, neg, mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite;
  logic       irwrite, memtoreg, regwrite, alusrca;
  logic [1:0] regdest, alusrcb, pcsource;
  logic [2:0] aluop;
  logic [3:0] state;
  logic       instr_done, illegal;
`ifdef MC_PERF_CNT_EN
  logic [31:0] retired, stall_cycles;
`endif

  mc_control dut (
    .clk(clk), .rst_n(rst_n),
    .opcode(opcode), .funct(funct),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca),
    .regdest(regdest), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource),
    .state(state), .instr_done(instr_done),
    .illegal(illegal)
`ifdef MC_PERF_CNT_EN
    , .retired(retired), .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] IRW = 8'b1000_0000;
  localparam logic [7:0] PCW = 8'b0100_0000;
  localparam logic [7:0] PWC = 8'b0010_0000;
  localparam logic [7:0] RGW = 8'b0001_0000;
  localparam logic [7:0] MRD = 8'b0000_1000;
  localparam logic [7:0] MWR = 8'b0000_0100;
  localparam logic [7:0] DON = 8'b0000_0010;
  localparam logic [7:0] MTR = 8'b0000_0001;

  localparam int K_LW = 0, K_SW = 1, K_RALU = 2, K_JMXOR = 3;
  localparam int K_BRV = 4, K_BEQ = 5, K_NORI = 6, K_BLEZAL = 7;
  localparam int K_JALPC = 8, K_BALN = 9, K_ILL = 10;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic [7:0] sb;
    logic [1:0] rd;
    logic [1:0] ps;
    logic       ill;
  } step_t;

  step_t plan[$];
  int    checks = 0;
  int    errors = 0;
  logic  ill_exp;
  int    ret_m, stall_m;

  logic [7:0] sb_obs;
  assign sb_obs = {irwrite, pcwrite, pcwritecond, regwrite,
                   memread, memwrite, instr_done, memtoreg};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h0F: return K_NORI;
      6'h24: return K_BLEZAL;
      6'h1F: return K_JALPC;
      6'h1B: return K_BALN;
      6'h00: begin
        if (fn == 6'h21) return K_JMXOR;
        if (fn == 6'h14) return K_BRV;
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A})
          return K_RALU;
        return K_ILL;
      end
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic step_t mk(input int st, input logic mr,
                               input logic [7:0] sb,
                               input int rd, input int ps);
    step_t s;
    s.st = 4'(st); s.mr = mr; s.sb = sb;
    s.rd = 2'(rd); s.ps = 2'(ps); s.ill = 1'b0;
    return s;
  endfunction

  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input int fst, input int mst,
                       input logic z, input logic n);
    step_t s;
    int    k;
    k = kind(op, fn);
    opcode = op; funct = fn; zero = z; neg = n;
    plan.delete();
    repeat (fst) plan.push_back(mk(0, 1'b0, MRD, 0, 0));
    plan.push_back(mk(0, 1'b1, IRW | PCW | MRD, 0, 0));
    s = mk(1, rbit(), 8'h00, 0, 0);
    s.ill = (k == K_ILL);
    plan.push_back(s);
    case (k)
      K_LW: begin
        plan.push_back(mk(2, rbit(), 8'h00, 0, 0));
        repeat (mst) plan.push_back(mk(3, 1'b0, MRD, 0, 0));
        plan.push_back(mk(3, 1'b1, MRD, 0, 0));
        plan.push_back(mk(4, rbit(), RGW | DON | MTR, 0, 0));
      end
      K_SW: begin
        plan.push_back(mk(2, rbit(), 8'h00, 0, 0));
        repeat (mst) plan.push_back(mk(5, 1'b0, MWR, 0, 0));
        plan.push_back(mk(5, 1'b1, MWR | DON, 0, 0));
      end
      K_RALU: begin
        plan.push_back(mk(6, rbit(), 8'h00, 0, 0));
        plan.push_back(mk(7, rbit(), RGW | DON, 1, 0));
      end
      K_JMXOR: begin
        plan.push_back(mk(6, rbit(), 8'h00, 0, 0));
        plan.push_back(mk(7, rbit(), RGW | PCW | DON, 2, 1));
      end
      K_BRV:  plan.push_back(mk(12, rbit(), PCW | DON, 0, 3));
      K_BEQ:  plan.push_back(mk(8, rbit(), PWC | DON, 0, 1));
      K_NORI: begin
        plan.push_back(mk(9, rbit(), 8'h00, 0, 0));
        plan.push_back(mk(10, rbit(), RGW | DON, 0, 0));
      end
      K_BLEZAL: plan.push_back(mk(11, rbit(),
                  RGW | DON | ((z | n) ? PCW : 8'h00), 2, 1));
      K_JALPC:  plan.push_back(mk(11, rbit(), RGW | PCW | DON, 2, 1));
      K_BALN:   plan.push_back(mk(11, rbit(),
                  RGW | DON | (n ? PCW : 8'h00), 2, 2));
      default: ;
    endcase
  endtask

  task automatic run_plan(input int lim);
    int n;
    n = (lim < 0) ? plan.size() : lim;
    for (int i = 0; i < n; i++) begin
      mem_ready = plan[i].mr;
      #1;
      chk("state", 32'(state), 32'(plan[i].st));
      chk("strobes", 32'(sb_obs), 32'(plan[i].sb));
      chk("illegal", 32'(illegal), 32'(ill_exp));
      if ((plan[i].sb & RGW) != 8'h00)
        chk("regdest", 32'(regdest), 32'(plan[i].rd));
      if ((plan[i].sb & (PCW | PWC)) != 8'h00)
        chk("pcsource", 32'(pcsource), 32'(plan[i].ps));
      @(posedge clk);
      if ((plan[i].sb & DON) != 8'h00) ret_m++;
      if (!plan[i].mr && plan[i].st inside {4'd0, 4'd3, 4'd5})
        stall_m++;
      if (plan[i].ill) ill_exp = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(sb_obs), 32'(MRD));
    chk("rst_illegal", 32'(illegal), 32'd0);
`ifdef MC_PERF_CNT_EN
    chk("rst_retired", retired, 32'd0);
    chk("rst_stalls", stall_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    ill_exp = 1'b0;
    ret_m = 0;
    stall_m = 0;
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] fns [8];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h24, 6'h1F, 6'h1B};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h21, 6'h14};
    rst_n = 1'b0; mem_ready = 1'b1;
    opcode = 6'h00; funct = 6'h20; zero = 1'b0; neg = 1'b0;
    ill_exp = 1'b0; ret_m = 0; stall_m = 0;
    @(negedge clk);
    do_reset(2);

    build(6'h23, 6'h00, 0, 3, 1'b0, 1'b0); run_plan(-1);
    build(6'h24, 6'h00, 0, 0, 1'b0, 1'b1); run_plan(-1);
    build(6'h24, 6'h00, 0, 0, 1'b0, 1'b0); run_plan(-1);
    build(6'h00, 6'h21, 1, 0, 1'b0, 1'b0); run_plan(-1);
    build(6'h00, 6'h14, 0, 0, 1'b0, 1'b0); run_plan(-1);
    build(6'h1B, 6'h00, 0, 0, 1'b1, 1'b1); run_plan(-1);
    build(6'h3E, 6'h00, 0, 0, 1'b0, 1'b0); run_plan(-1);
    build(6'h2B, 6'h00, 1, 1, 1'b0, 1'b0); run_plan(-1);
    build(6'h00, 6'h3F, 0, 0, 1'b0, 1'b0); run_plan(-1);

    // abort a stalled store: F, D, MEMADR, first MEMWR wait
    build(6'h2B, 6'h00, 0, 3, 1'b0, 1'b0); run_plan(4);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd5);
    chk("abort_memwrite", 32'(memwrite), 32'd0);
    chk("abort_strobes", 32'(sb_obs), 32'd0);
    do_reset(1);

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        8: begin op = 6'($urandom); fn = 6'($urandom); end
        9: begin op = 6'h00; fn = 6'($urandom); end
        default: begin
          op = ops[$urandom_range(0, 7)];
          fn = fns[$urandom_range(0, 7)];
        end
      endcase
      build(op, fn, $urandom_range(0, 2), $urandom_range(0, 3),
            rbit(), rbit());
      run_plan(-1);
      if (i % 50 == 49) do_reset(1);
    end

`ifdef MC_PERF_CNT_EN
    #1;
    chk("rand_retired", retired, 32'(ret_m));
    chk("rand_stalls", stall_cycles, 32'(stall_m));
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      build(6'h2B, 6'h00, 0, 2, 1'b0, 1'b0);
      run_plan(-1);
    end
    #1;
    chk("perf_retired", retired, 32'd10);
    chk("perf_stalls", stall_cycles, 32'd20);
    chk("perf_model", retired + stall_cycles, 32'(ret_m + stall_m));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
